// File: rtl/param_seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a WIDTH-cycle
// shift-add unsigned multiplier, with registered result and flags.
module param_seq_alu #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inc,
  input  logic [2:0]       opc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg,
  output logic             cout
);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b110;

  state_t state;
  state_t state_nxt;

  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcd;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mpl;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] res;
  logic             res_c;

  assign busy    = (state == S_MUL);
  assign accept  = start && (state == S_IDLE);
  assign last    = (state == S_MUL) && (cnt == CNTW'(WIDTH - 1));
  assign acc_nxt = mpl[0] ? acc + mcd : acc;

  assign sum = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, inc};
  assign dif = {1'b0, inA} - {1'b0, inB} - {{WIDTH{1'b0}}, inc};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    unique case (opc)
      3'b000: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
      end
      3'b001: begin
        res   = dif[WIDTH-1:0];
        res_c = dif[WIDTH];
      end
      3'b010: res = inA & inB;
      3'b011: res = inA | inB;
      3'b100: res = inA ^ inB;
      3'b101: begin
        res   = {inA[WIDTH-2:0], inc};
        res_c = inA[WIDTH-1];
      end
      3'b110: res = '0;
      3'b111: res = {{(WIDTH-1){1'b0}}, $signed(inA) < $signed(inB)};
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept && opc == OP_MUL) state_nxt = S_MUL;
      S_MUL:  if (last) state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w    <= '0;
      zer  <= 1'b1;
      neg  <= 1'b0;
      cout <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      mcd  <= '0;
      mpl  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (opc == OP_MUL) begin
          acc <= '0;
          cnt <= '0;
          mcd <= {{WIDTH{1'b0}}, inA};
          mpl <= inB;
        end else begin
          w    <= res;
          zer  <= (res == '0);
          neg  <= res[WIDTH-1];
          cout <= res_c;
          done <= 1'b1;
        end
      end else if (state == S_MUL) begin
        acc <= acc_nxt;
        mcd <= mcd << 1;
        mpl <= mpl >> 1;
        cnt <= cnt + CNTW'(1);
        // final iteration: publish product straight from the adder
        if (last) begin
          w    <= acc_nxt[WIDTH-1:0];
          zer  <= (acc_nxt[WIDTH-1:0] == '0);
          neg  <= acc_nxt[WIDTH-1];
          cout <= |acc_nxt[2*WIDTH-1:WIDTH];
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_seq_alu.sv
// Directed bench for param_seq_alu at WIDTH=16 and WIDTH=8.
module tb_param_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        c16 = 1'b0;
  logic [2:0]  opc16 = '0;
  logic        busy16, done16, zer16, neg16, cout16;
  logic [15:0] w16;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        c8 = 1'b0;
  logic [2:0]  opc8 = '0;
  logic        busy8, done8, zer8, neg8, cout8;
  logic [7:0]  w8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16),
    .inA(a16), .inB(b16), .inc(c16), .opc(opc16),
    .busy(busy16), .done(done16), .w(w16),
    .zer(zer16), .neg(neg16), .cout(cout16)
  );

  param_seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .inA(a8), .inB(b8), .inc(c8), .opc(opc8),
    .busy(busy8), .done(done8), .w(w8),
    .zer(zer8), .neg(neg8), .cout(cout8)
  );

  function automatic logic [8:0] exp8(input logic [2:0] op,
                                      input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic c);
    logic [8:0]  r;
    logic [15:0] p;
    r = '0;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b} + {8'd0, c};
      3'd1: r = {1'b0, a} - {1'b0, b} - {8'd0, c};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {a, c};
      3'd6: begin
        p = {8'd0, a} * {8'd0, b};
        r = {|p[15:8], p[7:0]};
      end
      default: r = {8'd0, $signed(a) < $signed(b)};
    endcase
    return r;
  endfunction

  task automatic run8(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic c,
                      output int lat);
    @(negedge clk);
    start8 = 1'b1; opc8 = op; a8 = a; b8 = b; c8 = c;
    @(posedge clk); #1;
    lat = 0;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom_range(255));
    b8 = 8'($urandom_range(255));
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({busy16, done16, w16, zer16, neg16, cout16} !== 21'b0_0_0000000000000000_1_0_0) begin
      errors++;
      $display("FAIL reset16 got b%b d%b w%h z%b n%b c%b want b0 d0 w0000 z1 n0 c0",
               busy16, done16, w16, zer16, neg16, cout16);
    end
    checks++;
    if ({busy8, done8, w8, zer8, neg8, cout8} !== 13'b0_0_00000000_1_0_0) begin
      errors++;
      $display("FAIL reset8 got b%b d%b w%h z%b n%b c%b want b0 d0 w00 z1 n0 c0",
               busy8, done8, w8, zer8, neg8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add16;
    @(negedge clk);
    start16 = 1'b1; opc16 = 3'b000; a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({done16, busy16, w16, zer16, neg16, cout16} !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add16 got d%b b%b w%h z%b n%b c%b want d1 b0 w0000 z1 n0 c1",
               done16, busy16, w16, zer16, neg16, cout16);
    end
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({done16, w16, cout16} !== {1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL add16_hold got d%b w%h c%b want d0 w0000 c1", done16, w16, cout16);
    end
  endtask

  task automatic test_sub16;
    @(negedge clk);
    start16 = 1'b1; opc16 = 3'b001; a16 = 16'h0003; b16 = 16'h0005; c16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({done16, w16, zer16, neg16, cout16} !== {1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub16 got d%b w%h z%b n%b c%b want d1 wfffe z0 n1 c1",
               done16, w16, zer16, neg16, cout16);
    end
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic test_logic16;
    logic [2:0]  op [4] = '{3'b101, 3'b100, 3'b111, 3'b010};
    logic [15:0] ta [4] = '{16'h8001, 16'hF0F0, 16'h7FFF, 16'hFFFF};
    logic [15:0] tb [4] = '{16'h0000, 16'hFF00, 16'h8000, 16'hFFFF};
    logic        tc [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] ew [4] = '{16'h0003, 16'h0FF0, 16'h0000, 16'hFFFF};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start16 = 1'b1; opc16 = op[i]; a16 = ta[i]; b16 = tb[i]; c16 = tc[i];
      @(posedge clk); #1;
      checks++;
      if ({done16, w16, cout16} !== {1'b1, ew[i], ec[i]}) begin
        errors++;
        $display("FAIL logic16[%0d] got d%b w%h c%b want d1 w%h c%b",
                 i, done16, w16, cout16, ew[i], ec[i]);
      end
    end
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic test_mul16;
    int n;
    test_sub16();
    @(negedge clk);
    start16 = 1'b1; opc16 = 3'b110; a16 = 16'h0100; b16 = 16'h0100; c16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy16, done16, w16, neg16} !== {1'b1, 1'b0, 16'hFFFE, 1'b1}) begin
      errors++;
      $display("FAIL mul16_accept got b%b d%b w%h n%b want b1 d0 wfffe n1",
               busy16, done16, w16, neg16);
    end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start16 = (k == 3);
      opc16 = 3'b000;
      a16 = 16'(k * 16'h1111);
      b16 = 16'h0001;
      @(posedge clk); #1;
      checks++;
      if ({busy16, done16, w16, zer16, neg16, cout16} !== {1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL mul16_run[%0d] got b%b d%b w%h z%b n%b c%b want b1 d0 wfffe z0 n1 c1",
                 k, busy16, done16, w16, zer16, neg16, cout16);
      end
    end
    @(negedge clk);
    start16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy16, done16, w16, zer16, neg16, cout16} !== {1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul16_done got b%b d%b w%h z%b n%b c%b want b0 d1 w0000 z1 n0 c1",
               busy16, done16, w16, zer16, neg16, cout16);
    end
    @(negedge clk);
    start16 = 1'b1; opc16 = 3'b110; a16 = 16'h00FF; b16 = 16'h0003;
    @(posedge clk); #1;
    checks++;
    if ({busy16, done16} !== 2'b10) begin
      errors++;
      $display("FAIL mul16_b2b got b%b d%b want b1 d0", busy16, done16);
    end
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 16 || {w16, zer16, neg16, cout16} !== {16'h02FD, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul16_ff3 got lat%0d w%h z%b n%b c%b want lat16 w02fd z0 n0 c0",
               n, w16, zer16, neg16, cout16);
    end
  endtask

  task automatic test_mul_rst16;
    int seen;
    @(negedge clk);
    start16 = 1'b1; opc16 = 3'b110; a16 = 16'h1234; b16 = 16'h0005;
    @(posedge clk); #1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy16, done16, w16, zer16} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL mul16_rst got b%b d%b w%h z%b want b0 d0 w0000 z1",
               busy16, done16, w16, zer16);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mul16_abort got %0d cycles with done/busy want 0", seen);
    end
  endtask

  task automatic test_w8;
    int lat;
    run8(3'b111, 8'h80, 8'h01, 1'b0, lat);
    checks++;
    if ({lat, w8, cout8} !== {32'd0, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL slt8 got lat%0d w%h c%b want lat0 w01 c0", lat, w8, cout8);
    end
    run8(3'b110, 8'h0F, 8'h11, 1'b0, lat);
    checks++;
    if ({lat, w8, neg8, cout8} !== {32'd8, 8'hFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul8 got lat%0d w%h n%b c%b want lat8 wff n1 c0", lat, w8, neg8, cout8);
    end
  endtask

  task automatic test_random8;
    int         lat;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] e;
    for (int i = 0; i < 48; i++) begin
      op = 3'(i % 8);
      a  = 8'($urandom_range(255));
      b  = 8'($urandom_range(255));
      c  = 1'($urandom_range(1));
      e  = exp8(op, a, b, c);
      run8(op, a, b, c, lat);
      checks++;
      if (lat !== (op == 3'b110 ? 8 : 0) || w8 !== e[7:0] || cout8 !== e[8] ||
          zer8 !== (e[7:0] == 8'h00) || neg8 !== e[7]) begin
        errors++;
        $display("FAIL rand8[%0d] op%0d a%h b%h c%b got lat%0d w%h c%b z%b n%b want w%h c%b",
                 i, op, a, b, c, lat, w8, cout8, zer8, neg8, e[7:0], e[8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add16();
    test_sub16();
    test_logic16();
    test_mul16();
    test_mul_rst16();
    test_w8();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width (legal 4..64).
REQ-002 SHALL have parameter CNTW, default $clog2(WIDTH)+1, multiply iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request pulse; operands/opcode sampled when accepted.
REQ-006 SHALL have port inA  input  WIDTH  operand A.
REQ-007 SHALL have port inB  input  WIDTH  operand B.
REQ-008 SHALL have port inc  input  1  carry/borrow-in, shift-in bit.
REQ-009 SHALL have port opc  input  3  opcode.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-012 SHALL have port w  output  WIDTH  registered result.
REQ-013 SHALL have port zer  output  1  w == 0.
REQ-014 SHALL have port neg  output  1  w[WIDTH-1].
REQ-015 SHALL have port cout  output  1  carry/borrow/overflow flag.

Function
REQ-016 SHALL accept start only when busy=0 at a rising edge; start with busy=1 ignored, no state change.
REQ-017 SHALL implement opcodes: 000 ADD w=inA+inB+inc, cout=carry-out; 001 SUB w=inA-inB-inc, cout=1 on borrow; 010 AND; 011 OR; 100 XOR; 101 SHL w={inA[WIDTH-2:0],inc}, cout=inA[WIDTH-1]; 110 MUL unsigned, w=low WIDTH bits of product, cout=1 if high WIDTH bits nonzero; 111 SLT w=1 if signed inA < signed inB else 0.
REQ-018 SHALL force cout=0 for opcodes 010, 011, 100, 111.
REQ-019 SHALL derive zer and neg from the value registered into w, updated on the same edge as w.
REQ-020 SHALL, for opcodes other than 110, register w/zer/neg/cout on the accepting edge and assert done for exactly the following cycle (latency 1); busy stays 0.
REQ-021 SHALL use FSM states IDLE and MUL; IDLE->MUL on accepted start with opc=110; MUL->IDLE after iteration WIDTH; MUL has no other exit except rst.
REQ-022 SHALL, on accepting MUL, latch inA/inB, clear accumulator and counter, set busy=1 on that edge.
REQ-023 SHALL perform one shift-add iteration per cycle in MUL, WIDTH iterations total (edges 1..WIDTH after acceptance).
REQ-024 SHALL, on edge WIDTH after acceptance, register w/zer/neg/cout, clear busy, assert done for one cycle.
REQ-025 SHALL hold w/zer/neg/cout unchanged between done pulses, including throughout MUL.
REQ-026 SHALL allow a new start in the cycle done is high (back-to-back operation).
REQ-027 SHALL ignore operand/opcode changes after acceptance.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set state=IDLE, busy=0, done=0, w=0, zer=1, neg=0, cout=0, counter=0.
REQ-029 SHALL give rst priority over start; rst during MUL aborts with no done pulse.

Verification
REQ-030 WIDTH=16, ADD inA=0xFFFF inB=0x0001 inc=0 -> next cycle done=1, w=0x0000, zer=1, cout=1, neg=0.
REQ-031 WIDTH=16, SUB inA=0x0003 inB=0x0005 inc=0 -> w=0xFFFE, neg=1, cout=1, zer=0.
REQ-032 WIDTH=16, MUL 0x0100*0x0100 -> busy=1 for 16 cycles, done on 16th edge after start, w=0x0000, zer=1, cout=1; MUL 0x00FF*0x0003 -> w=0x02FD, cout=0.
REQ-033 WIDTH=16, ADD start pulsed mid-MUL -> ignored; MUL result and timing unchanged.
REQ-034 WIDTH=16, rst at 5th cycle of MUL -> next edge busy=0, w=0, zer=1; no done afterwards.
REQ-035 WIDTH=8, SLT inA=0x80 inB=0x01 -> w=0x01; MUL 0x0F*0x11 -> w=0xFF, done 8 cycles after start; random single-cycle ops vs. behavioural model, all 8 opcodes.
